// File: rtl/south_result_collector.sv
// South-edge result collector: one FIFO per skewed column, emits whole de-skewed
// rows on a valid/ready stream and signals done after ROWS rows are handed off.
module south_result_collector #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int ROWS       = 8
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    start_i,
    input  logic [DATA_WIDTH-1:0]   south_i [0:N-1],
    input  logic [N-1:0]            south_valid_i,
    output logic [N*DATA_WIDTH-1:0] row_o,
    output logic                    row_valid_o,
    input  logic                    row_ready_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    overflow_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(ROWS + 1);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           row_cnt_q, row_cnt_d;
    logic                    row_valid_q, row_valid_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    overflow_q, overflow_d;
    logic [N*DATA_WIDTH-1:0] row_q, row_d;

    logic [N-1:0]            empty;
    logic [N-1:0]            full;
    logic [N-1:0]            wr_en;
    logic [N-1:0]            drop;
    logic [DATA_WIDTH-1:0]   rd_data [N];

    logic collect, start_collect, handshake, finish, pop, clr;

    assign collect       = (state_q == COLLECT);
    assign start_collect = (state_q != COLLECT) && start_i;
    assign handshake     = row_valid_q && row_ready_i;
    assign finish        = collect && handshake && (row_cnt_q == CW'(ROWS - 1));
    assign pop           = collect && (&(~empty)) && (!row_valid_q || row_ready_i);
    // Starting a new operation and finishing the current one both discard FIFO contents.
    assign clr           = start_collect || finish;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_col
            logic [AW:0]           wr_ptr_q, wr_ptr_d;
            logic [AW:0]           rd_ptr_q, rd_ptr_d;
            logic [DATA_WIDTH-1:0] mem [DEPTH];

            assign empty[gi]   = (wr_ptr_q == rd_ptr_q);
            assign full[gi]    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
            // A full column still accepts a write when the row pop frees a slot on the same edge.
            assign wr_en[gi]   = collect && south_valid_i[gi] && (!full[gi] || pop);
            assign drop[gi]    = collect && south_valid_i[gi] && full[gi] && !pop;
            assign rd_data[gi] = mem[rd_ptr_q[AW-1:0]];

            always_comb begin
                wr_ptr_d = wr_ptr_q;
                rd_ptr_d = rd_ptr_q;
                if (clr) begin
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                end else begin
                    if (wr_en[gi]) wr_ptr_d = wr_ptr_q + 1'b1;
                    if (pop)       rd_ptr_d = rd_ptr_q + 1'b1;
                end
            end

            always_ff @(posedge clk_i) begin
                if (!rstn_i) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                end else begin
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                end
            end

            always_ff @(posedge clk_i) begin
                if (wr_en[gi]) mem[wr_ptr_q[AW-1:0]] <= south_i[gi];
            end
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        row_valid_d = row_valid_q;
        row_d       = row_q;
        overflow_d  = overflow_q;
        if (start_collect) begin
            state_d     = COLLECT;
            row_cnt_d   = '0;
            row_valid_d = 1'b0;
            row_d       = '0;
            overflow_d  = 1'b0;
        end else if (collect) begin
            if (|drop)     overflow_d = 1'b1;
            if (handshake) row_cnt_d  = row_cnt_q + 1'b1;
            if (finish) begin
                state_d     = DONE;
                row_valid_d = 1'b0;
            end else if (pop) begin
                row_valid_d = 1'b1;
                for (int j = 0; j < N; j++) row_d[j*DATA_WIDTH +: DATA_WIDTH] = rd_data[j];
            end else if (handshake) begin
                row_valid_d = 1'b0;
            end
        end
        busy_d = (state_d == COLLECT);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            row_cnt_q   <= '0;
            row_valid_q <= 1'b0;
            row_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            row_valid_q <= row_valid_d;
            row_q       <= row_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
        end
    end

    assign row_o       = row_q;
    assign row_valid_o = row_valid_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign overflow_o  = overflow_q;
endmodule

// File: tb/tb_south_result_collector.sv
// Bench for south_result_collector: directed skewed rows, row data checked by a
// scoreboard monitor on every handshake, status outputs checked inline.
module tb_south_result_collector;
    localparam int N     = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int ROWS  = 4;

    logic            clk_i = 1'b0;
    logic            rstn_i;
    logic            start_i;
    logic [DW-1:0]   south_i [0:N-1];
    logic [N-1:0]    south_valid_i;
    logic [N*DW-1:0] row_o;
    logic            row_valid_o;
    logic            row_ready_i;
    logic            busy_o;
    logic            done_o;
    logic            overflow_o;

    int              n_cmp = 0;
    int              n_err = 0;
    logic [N*DW-1:0] exp_q [$];
    logic [N*DW-1:0] mon_exp;
    logic [N*DW-1:0] r;

    always #5 clk_i = ~clk_i;

    south_result_collector #(
        .N(N), .DATA_WIDTH(DW), .DEPTH(DEPTH), .ROWS(ROWS)
    ) u_dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i),
        .south_i(south_i), .south_valid_i(south_valid_i),
        .row_o(row_o), .row_valid_o(row_valid_o), .row_ready_i(row_ready_i),
        .busy_o(busy_o), .done_o(done_o), .overflow_o(overflow_o)
    );

    function automatic logic [N*DW-1:0] row_of(input logic [DW-1:0] base);
        logic [N*DW-1:0] v;
        for (int j = 0; j < N; j++) v[j*DW +: DW] = base + DW'(j);
        return v;
    endfunction

    task automatic check(input string name, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_row(input logic [DW-1:0] base);
        for (int k = 0; k < N; k++) begin
            south_valid_i    = '0;
            south_valid_i[k] = 1'b1;
            south_i[k]       = base + DW'(k);
            tick();
        end
        south_valid_i = '0;
    endtask

    task automatic restart();
        rstn_i = 1'b0;
        tick();
        rstn_i  = 1'b1;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // Scoreboard monitor: every handshake must match the oldest queued row.
    always @(negedge clk_i) begin
        if (rstn_i === 1'b1 && row_valid_o && row_ready_i) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL row_handshake: got %0h required no row", row_o);
            end else begin
                mon_exp = exp_q.pop_front();
                if (row_o !== mon_exp) begin
                    n_err++;
                    $display("FAIL row_handshake: got %0h required %0h", row_o, mon_exp);
                end else begin
                    $display("ok   row_handshake: %0h", row_o);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    initial begin
        rstn_i = 1'b0; start_i = 1'b0; row_ready_i = 1'b0;
        south_valid_i = '1;
        for (int j = 0; j < N; j++) south_i[j] = 32'hFF;

        // Reset with column valids asserted
        tick(); tick();
        check("rst_row_valid", row_valid_o, 0);
        check("rst_row", row_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_overflow", overflow_o, 0);
        rstn_i = 1'b1; south_valid_i = '0;
        tick(); tick();
        check("idle_row_valid", row_valid_o, 0);
        check("idle_busy", busy_o, 0);

        // Skewed row and latency
        restart();
        check("start_busy", busy_o, 1);
        send_row(32'h10);
        check("latency_not_yet", row_valid_o, 0);
        tick();
        check("latency_valid", row_valid_o, 1);
        check("latency_row", row_o, row_of(32'h10));
        exp_q.push_back(row_of(32'h10));
        row_ready_i = 1'b1;
        tick();
        row_ready_i = 1'b0;
        check("single_transfer", row_valid_o, 0);

        // Backpressure: two rows queue up behind a stalled output
        restart();
        send_row(32'h10);
        send_row(32'h20);
        check("bp_valid", row_valid_o, 1);
        check("bp_row", row_o, row_of(32'h10));
        tick(); tick();
        check("bp_hold_valid", row_valid_o, 1);
        check("bp_hold_row", row_o, row_of(32'h10));
        check("bp_overflow", overflow_o, 0);
        exp_q.push_back(row_of(32'h10));
        exp_q.push_back(row_of(32'h20));
        row_ready_i = 1'b1;
        tick();
        check("bp_b2b_valid", row_valid_o, 1);
        check("bp_b2b_row", row_o, row_of(32'h20));
        tick();
        row_ready_i = 1'b0;
        check("bp_drain", row_valid_o, 0);

        // Overflow on column 0, then drain to DONE
        restart();
        for (int k = 1; k <= 5; k++) begin
            south_valid_i = 4'b0001;
            south_i[0]    = DW'(k);
            tick();
            if (k == 4) check("ovf_before", overflow_o, 0);
            if (k == 5) check("ovf_after", overflow_o, 1);
        end
        for (int k = 1; k <= 4; k++) begin
            south_valid_i = 4'b1110;
            for (int j = 1; j < N; j++) south_i[j] = DW'(32'h100 * j + k);
            r = '0;
            r[DW-1:0] = DW'(k);
            for (int j = 1; j < N; j++) r[j*DW +: DW] = DW'(32'h100 * j + k);
            exp_q.push_back(r);
            tick();
        end
        south_valid_i = '0;
        tick();
        check("ovf_sticky", overflow_o, 1);
        row_ready_i = 1'b1;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (done_o) break;
        end
        check("done_done", done_o, 1);
        check("done_busy", busy_o, 0);
        check("done_row_valid", row_valid_o, 0);

        // DONE ignores column traffic; restart clears status
        south_valid_i = '1;
        for (int j = 0; j < N; j++) south_i[j] = 32'hDEAD;
        for (int t = 0; t < 3; t++) begin
            tick();
            check("done_no_row", row_valid_o, 0);
        end
        south_valid_i = '0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("restart_busy", busy_o, 1);
        check("restart_done", done_o, 0);
        check("restart_overflow", overflow_o, 0);
        tick(); tick(); tick();
        check("restart_no_stale", row_valid_o, 0);

        // Reset in the middle of an operation
        row_ready_i = 1'b0;
        send_row(32'h40);
        south_valid_i = 4'b0001; south_i[0] = 32'h50; tick();
        south_valid_i = 4'b0010; south_i[1] = 32'h51; tick();
        south_valid_i = '0; tick();
        check("mid_valid", row_valid_o, 1);
        rstn_i = 1'b0;
        tick();
        check("mid_rst_valid", row_valid_o, 0);
        check("mid_rst_row", row_o, 0);
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_done", done_o, 0);
        check("mid_rst_overflow", overflow_o, 0);
        rstn_i = 1'b1;
        tick();
        check("mid_idle_busy", busy_o, 0);
        start_i = 1'b1; tick(); start_i = 1'b0;
        south_valid_i = 4'b0100; south_i[2] = 32'h52; tick();
        south_valid_i = 4'b1000; south_i[3] = 32'h53; tick();
        south_valid_i = '0;
        tick(); tick();
        check("mid_no_stale_row", row_valid_o, 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
